// File: rtl/dcache_port_arbiter_if.sv
// Bus bundle between the two data-cache clients (MMU walker, LSU), the flush
// requester and the single data-cache request port.
// The slave modport is the arbiter's view and the master modport is the
// surrounding logic's view.
interface dcache_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic              mmu_req_i;
   logic [ADDR_W-1:0] mmu_addr_i;
   logic              mmu_ack_o;
   logic [DATA_W-1:0] mmu_rdata_o;

   logic              lsu_req_i;
   logic              lsu_w_en_i;
   logic [ADDR_W-1:0] lsu_addr_i;
   logic [DATA_W-1:0] lsu_wdata_i;
   logic [SEL_W-1:0]  lsu_sel_i;
   logic              lsu_ack_o;
   logic [DATA_W-1:0] lsu_rdata_o;

   logic              flush_req_i;
   logic              flush_ack_o;

   logic              dc_req_o;
   logic              dc_w_en_o;
   logic [ADDR_W-1:0] dc_addr_o;
   logic [DATA_W-1:0] dc_wdata_o;
   logic [SEL_W-1:0]  dc_sel_o;
   logic              dc_ack_i;
   logic [DATA_W-1:0] dc_rdata_i;
   logic              dc_flush_o;
   logic              dc_flush_ack_i;

   modport slave (
      input  mmu_req_i, mmu_addr_i,
      output mmu_ack_o, mmu_rdata_o,
      input  lsu_req_i, lsu_w_en_i, lsu_addr_i, lsu_wdata_i, lsu_sel_i,
      output lsu_ack_o, lsu_rdata_o,
      input  flush_req_i,
      output flush_ack_o,
      output dc_req_o, dc_w_en_o, dc_addr_o, dc_wdata_o, dc_sel_o,
      input  dc_ack_i, dc_rdata_i,
      output dc_flush_o,
      input  dc_flush_ack_i
   );

   modport master (
      output mmu_req_i, mmu_addr_i,
      input  mmu_ack_o, mmu_rdata_o,
      output lsu_req_i, lsu_w_en_i, lsu_addr_i, lsu_wdata_i, lsu_sel_i,
      input  lsu_ack_o, lsu_rdata_o,
      output flush_req_i,
      input  flush_ack_o,
      input  dc_req_o, dc_w_en_o, dc_addr_o, dc_wdata_o, dc_sel_o,
      output dc_ack_i, dc_rdata_i,
      input  dc_flush_o,
      output dc_flush_ack_i
   );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Data-cache port arbiter.
// It takes requests from the MMU page-table walker and the LSU and grants
// them round-robin. The granted request is registered onto the single
// data-cache port, and the response goes back to the client that owns it.
// A pending flush may let at most one client grant go ahead of it before it
// takes the port.
module dcache_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   dcache_port_arbiter_if.slave bus
);
   localparam int SEL_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SERV_MMU = 2'd1,
      SERV_LSU = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   typedef enum logic {
      GRANT_MMU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_t;

   state_t            state_q, state_d;
   grant_t            last_grant_q, last_grant_d;
   logic              flush_owed_q, flush_owed_d;
   logic              dc_req_q, dc_req_d;
   logic              dc_w_en_q, dc_w_en_d;
   logic [ADDR_W-1:0] dc_addr_q, dc_addr_d;
   logic [DATA_W-1:0] dc_wdata_q, dc_wdata_d;
   logic [SEL_W-1:0]  dc_sel_q, dc_sel_d;
   logic              dc_flush_q, dc_flush_d;
   logic              any_req;
   logic              pick_mmu;

   // Next-state, grant capture and flush-ordering decision
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      flush_owed_d = flush_owed_q;
      dc_req_d     = dc_req_q;
      dc_w_en_d    = dc_w_en_q;
      dc_addr_d    = dc_addr_q;
      dc_wdata_d   = dc_wdata_q;
      dc_sel_d     = dc_sel_q;
      any_req      = bus.mmu_req_i | bus.lsu_req_i;
      pick_mmu     = bus.mmu_req_i & (~bus.lsu_req_i | (last_grant_q == GRANT_LSU));

      case (state_q)
         IDLE: begin
            if (bus.flush_req_i && (!any_req || flush_owed_q)) begin
               state_d      = FLUSH;
               flush_owed_d = 1'b0;
            end else if (pick_mmu) begin
               state_d      = SERV_MMU;
               flush_owed_d = bus.flush_req_i;
               dc_req_d     = 1'b1;
               dc_w_en_d    = 1'b0;
               dc_addr_d    = bus.mmu_addr_i;
               dc_wdata_d   = '0;
               dc_sel_d     = '1;
            end else if (bus.lsu_req_i) begin
               state_d      = SERV_LSU;
               flush_owed_d = bus.flush_req_i;
               dc_req_d     = 1'b1;
               dc_w_en_d    = bus.lsu_w_en_i;
               dc_addr_d    = bus.lsu_addr_i;
               dc_wdata_d   = bus.lsu_wdata_i;
               dc_sel_d     = bus.lsu_sel_i;
            end
         end
         SERV_MMU: begin
            if (bus.dc_ack_i) begin
               state_d      = IDLE;
               last_grant_d = GRANT_MMU;
               dc_req_d     = 1'b0;
               dc_w_en_d    = 1'b0;
               dc_addr_d    = '0;
               dc_wdata_d   = '0;
               dc_sel_d     = '0;
            end
         end
         SERV_LSU: begin
            if (bus.dc_ack_i) begin
               state_d      = IDLE;
               last_grant_d = GRANT_LSU;
               dc_req_d     = 1'b0;
               dc_w_en_d    = 1'b0;
               dc_addr_d    = '0;
               dc_wdata_d   = '0;
               dc_sel_d     = '0;
            end
         end
         FLUSH: begin
            if (bus.dc_flush_ack_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      dc_flush_d = (state_d == FLUSH);
   end

   // State register and registered cache-port outputs, synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_LSU;
         flush_owed_q <= 1'b0;
         dc_req_q     <= 1'b0;
         dc_w_en_q    <= 1'b0;
         dc_addr_q    <= '0;
         dc_wdata_q   <= '0;
         dc_sel_q     <= '0;
         dc_flush_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         flush_owed_q <= flush_owed_d;
         dc_req_q     <= dc_req_d;
         dc_w_en_q    <= dc_w_en_d;
         dc_addr_q    <= dc_addr_d;
         dc_wdata_q   <= dc_wdata_d;
         dc_sel_q     <= dc_sel_d;
         dc_flush_q   <= dc_flush_d;
      end
   end

   // Response routing: acks are combinational and suppressed while in reset
   always_comb begin
      bus.mmu_ack_o   = rst_n & (state_q == SERV_MMU) & bus.dc_ack_i;
      bus.lsu_ack_o   = rst_n & (state_q == SERV_LSU) & bus.dc_ack_i;
      bus.flush_ack_o = rst_n & (state_q == FLUSH) & bus.dc_flush_ack_i;
      bus.mmu_rdata_o = '0;
      bus.lsu_rdata_o = '0;
      if (bus.mmu_ack_o) begin
         bus.mmu_rdata_o = bus.dc_rdata_i;
      end
      if (bus.lsu_ack_o) begin
         bus.lsu_rdata_o = bus.dc_rdata_i;
      end
   end

   assign bus.dc_req_o   = dc_req_q;
   assign bus.dc_w_en_o  = dc_w_en_q;
   assign bus.dc_addr_o  = dc_addr_q;
   assign bus.dc_wdata_o = dc_wdata_q;
   assign bus.dc_sel_o   = dc_sel_q;
   assign bus.dc_flush_o = dc_flush_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter.
// Expected cache-port transactions are queued as client requests are raised.
// A small cache responder pops and checks each one when dc_req_o appears,
// then acknowledges it.
module tb_dcache_port_arbiter;

   typedef struct {
      bit          is_mmu;
      logic        w_en;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
   } txn_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   passed;
   int   waited;
   int   w;
   txn_t sb[$];

   dcache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something hangs despite the bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else begin
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit is_mmu, input logic w_en, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] sel);
      txn_t e;
      e.is_mmu = is_mmu;
      if (is_mmu) begin
         bus.mmu_req_i  = 1'b1;
         bus.mmu_addr_i = addr;
         e.w_en  = 1'b0;
         e.addr  = addr;
         e.wdata = 32'h0;
         e.sel   = 4'hF;
      end else begin
         bus.lsu_req_i   = 1'b1;
         bus.lsu_w_en_i  = w_en;
         bus.lsu_addr_i  = addr;
         bus.lsu_wdata_i = wdata;
         bus.lsu_sel_i   = sel;
         e.w_en  = w_en;
         e.addr  = addr;
         e.wdata = wdata;
         e.sel   = sel;
      end
      sb.push_back(e);
   endtask

   task automatic serveCache(input int delay, input logic [31:0] rdata, input bit mutate, output int lat);
      txn_t e;
      int   n;
      n = 0;
      while (bus.dc_req_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      lat = n;
      checkOutput("dc_req_rise", bus.dc_req_o, 1);
      if (sb.size() == 0) begin
         checkOutput("sb_underflow", sb.size(), 1);
         return;
      end
      e = sb.pop_front();
      checkOutput("dc_w_en", bus.dc_w_en_o, e.w_en);
      checkOutput("dc_addr", bus.dc_addr_o, e.addr);
      checkOutput("dc_sel", bus.dc_sel_o, e.sel);
      if (!e.is_mmu) begin
         checkOutput("dc_wdata", bus.dc_wdata_o, e.wdata);
      end
      if (mutate) begin
         bus.lsu_addr_i  = 32'hFFFF_FFF0;
         bus.lsu_wdata_i = 32'h0BAD_0BAD;
         bus.lsu_sel_i   = 4'hC;
      end
      for (int i = 1; i < delay; i++) begin
         tick();
         checkOutput("hold_req", bus.dc_req_o, 1);
         checkOutput("hold_addr", bus.dc_addr_o, e.addr);
         checkOutput("hold_sel", bus.dc_sel_o, e.sel);
         checkOutput("early_ack", {bus.mmu_ack_o, bus.lsu_ack_o}, 0);
      end
      bus.dc_ack_i   = 1'b1;
      bus.dc_rdata_i = rdata;
      #1;
      if (e.is_mmu) begin
         checkOutput("mmu_ack", bus.mmu_ack_o, 1);
         checkOutput("mmu_rdata", bus.mmu_rdata_o, rdata);
         checkOutput("lsu_ack_quiet", bus.lsu_ack_o, 0);
         checkOutput("lsu_rdata_zero", bus.lsu_rdata_o, 0);
      end else begin
         checkOutput("lsu_ack", bus.lsu_ack_o, 1);
         checkOutput("lsu_rdata", bus.lsu_rdata_o, rdata);
         checkOutput("mmu_ack_quiet", bus.mmu_ack_o, 0);
         checkOutput("mmu_rdata_zero", bus.mmu_rdata_o, 0);
      end
      tick();
      bus.dc_ack_i   = 1'b0;
      bus.dc_rdata_i = 32'h0;
      if (e.is_mmu) begin
         bus.mmu_req_i = 1'b0;
      end else begin
         bus.lsu_req_i = 1'b0;
      end
      #1;
      checkOutput("dc_req_drop", bus.dc_req_o, 0);
      checkOutput("ack_clear", {bus.mmu_ack_o, bus.lsu_ack_o}, 0);
   endtask

   // Linear directed sequence
   initial begin
      checks = 0;
      passed = 0;
      rst_n  = 1'b0;
      bus.mmu_req_i      = 1'b0;
      bus.mmu_addr_i     = 32'h0;
      bus.lsu_req_i      = 1'b0;
      bus.lsu_w_en_i     = 1'b0;
      bus.lsu_addr_i     = 32'h0;
      bus.lsu_wdata_i    = 32'h0;
      bus.lsu_sel_i      = 4'h0;
      bus.flush_req_i    = 1'b0;
      bus.dc_ack_i       = 1'b0;
      bus.dc_rdata_i     = 32'h0;
      bus.dc_flush_ack_i = 1'b0;

      $display("[TB] reset");
      repeat (3) tick();
      checkOutput("rst_dc_req", bus.dc_req_o, 0);
      checkOutput("rst_dc_flush", bus.dc_flush_o, 0);
      checkOutput("rst_dc_addr", bus.dc_addr_o, 0);
      checkOutput("rst_dc_sel", bus.dc_sel_o, 0);
      checkOutput("rst_dc_w_en", bus.dc_w_en_o, 0);
      checkOutput("rst_dc_wdata", bus.dc_wdata_o, 0);
      checkOutput("rst_acks", {bus.mmu_ack_o, bus.lsu_ack_o, bus.flush_ack_o}, 0);
      rst_n = 1'b1;
      tick();

      $display("[TB] MMU read");
      applyStimulus(1'b1, 1'b0, 32'h8000_1000, 32'h0, 4'h0);
      serveCache(3, 32'hDEAD_BEEF, 1'b0, waited);
      checkOutput("mmu_latency", waited, 1);

      $display("[TB] LSU write with input change during service");
      applyStimulus(1'b0, 1'b1, 32'h8000_2004, 32'h1234_5678, 4'h3);
      serveCache(3, 32'hCAFE_0001, 1'b1, waited);
      checkOutput("lsu_latency", waited, 1);

      $display("[TB] simultaneous requests, round robin");
      for (int r = 0; r < 2; r++) begin
         applyStimulus(1'b1, 1'b0, 32'h8000_3000 + r * 32'h10, 32'h0, 4'h0);
         applyStimulus(1'b0, 1'b0, 32'h8000_3100 + r * 32'h10, 32'h0, 4'hF);
         serveCache(1, 32'h1111_0000 + r, 1'b0, waited);
         checkOutput("tie_first_latency", waited, 1);
         serveCache(1, 32'h2222_0000 + r, 1'b0, waited);
         checkOutput("tie_idle_gap", waited, 1);
      end

      $display("[TB] flush behind LSU and one MMU grant");
      applyStimulus(1'b0, 1'b1, 32'h8000_4000, 32'hA5A5_A5A5, 4'hF);
      tick();
      checkOutput("flush_lsu_active", bus.dc_req_o, 1);
      bus.flush_req_i = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h8000_5000, 32'h0, 4'h0);
      serveCache(2, 32'h3333_0000, 1'b0, waited);
      checkOutput("flush_lsu_first", waited, 0);
      serveCache(1, 32'h4444_0000, 1'b0, waited);
      checkOutput("flush_mmu_gap", waited, 1);
      applyStimulus(1'b0, 1'b0, 32'h8000_6000, 32'h0, 4'h1);
      w = 0;
      while (bus.dc_flush_o !== 1'b1 && w < 20) begin
         tick();
         checkOutput("flush_no_grant", bus.dc_req_o, 0);
         w++;
      end
      checkOutput("flush_rise", bus.dc_flush_o, 1);
      checkOutput("flush_latency", w, 1);
      repeat (2) begin
         tick();
         checkOutput("flush_hold", bus.dc_flush_o, 1);
         checkOutput("flush_hold_no_req", bus.dc_req_o, 0);
         checkOutput("flush_ack_early", bus.flush_ack_o, 0);
      end
      bus.dc_flush_ack_i = 1'b1;
      bus.dc_ack_i       = 1'b1;
      #1;
      checkOutput("flush_ack_pulse", bus.flush_ack_o, 1);
      checkOutput("flush_stray_ack", {bus.mmu_ack_o, bus.lsu_ack_o}, 0);
      tick();
      bus.dc_flush_ack_i = 1'b0;
      bus.dc_ack_i       = 1'b0;
      bus.flush_req_i    = 1'b0;
      #1;
      checkOutput("flush_ack_one_cycle", bus.flush_ack_o, 0);
      checkOutput("flush_drop", bus.dc_flush_o, 0);
      checkOutput("flush_after_no_req", bus.dc_req_o, 0);
      serveCache(1, 32'h5555_0000, 1'b0, waited);
      checkOutput("post_flush_lsu", waited, 1);

      $display("[TB] reset in the middle of an MMU service");
      applyStimulus(1'b1, 1'b0, 32'h8000_7000, 32'h0, 4'h0);
      serveCache(1, 32'h6666_0000, 1'b0, waited);
      bus.mmu_req_i  = 1'b1;
      bus.mmu_addr_i = 32'h8000_8000;
      tick();
      checkOutput("rst_mid_req", bus.dc_req_o, 1);
      checkOutput("rst_mid_addr", bus.dc_addr_o, 32'h8000_8000);
      rst_n          = 1'b0;
      bus.dc_ack_i   = 1'b1;
      bus.dc_rdata_i = 32'h7777_7777;
      #1;
      checkOutput("rst_mid_no_ack", bus.mmu_ack_o, 0);
      checkOutput("rst_mid_rdata", bus.mmu_rdata_o, 0);
      tick();
      rst_n          = 1'b1;
      bus.dc_ack_i   = 1'b0;
      bus.dc_rdata_i = 32'h0;
      bus.mmu_req_i  = 1'b0;
      #1;
      checkOutput("rst_mid_req_drop", bus.dc_req_o, 0);
      checkOutput("rst_mid_addr_clr", bus.dc_addr_o, 0);
      checkOutput("rst_mid_acks", {bus.mmu_ack_o, bus.lsu_ack_o, bus.flush_ack_o}, 0);
      applyStimulus(1'b1, 1'b0, 32'h8000_9000, 32'h0, 4'h0);
      applyStimulus(1'b0, 1'b1, 32'h8000_9100, 32'h0F0F_0F0F, 4'h8);
      serveCache(1, 32'h8888_0000, 1'b0, waited);
      checkOutput("rst_tie_mmu_first", waited, 1);
      serveCache(2, 32'h9999_0000, 1'b0, waited);
      checkOutput("rst_lsu_grant", waited, 1);

      $display("[TB] stray ack while idle");
      bus.dc_ack_i   = 1'b1;
      bus.dc_rdata_i = 32'hAAAA_5555;
      #1;
      checkOutput("idle_stray_ack", {bus.mmu_ack_o, bus.lsu_ack_o}, 0);
      checkOutput("idle_stray_rdata", bus.lsu_rdata_o, 0);
      tick();
      bus.dc_ack_i   = 1'b0;
      bus.dc_rdata_i = 32'h0;
      #1;
      checkOutput("idle_stray_no_req", bus.dc_req_o, 0);
      checkOutput("idle_stray_no_flush", bus.dc_flush_o, 0);
      applyStimulus(1'b0, 1'b0, 32'h8000_A000, 32'h0, 4'hF);
      serveCache(1, 32'hBBBB_0000, 1'b0, waited);
      checkOutput("idle_stray_then_lsu", waited, 1);
      checkOutput("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
